// File: rtl/framebuffer_scanout_pkg.sv
// Shared definitions for the framebuffer scanout slice: colour layout, default geometry/timing,
// scan counter and address widths, write-FSM state type.
package framebuffer_scanout_pkg;

  localparam int unsigned COLOUR_W = 9;
  localparam int unsigned R_HI = 8;
  localparam int unsigned R_LO = 6;
  localparam int unsigned G_HI = 5;
  localparam int unsigned G_LO = 3;
  localparam int unsigned B_HI = 2;
  localparam int unsigned B_LO = 0;

  localparam int unsigned DEF_FB_W   = 160;
  localparam int unsigned DEF_FB_H   = 120;
  localparam int unsigned DEF_H_FP   = 8;
  localparam int unsigned DEF_H_SYNC = 24;
  localparam int unsigned DEF_H_BP   = 8;
  localparam int unsigned DEF_V_FP   = 2;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 4;

  localparam logic [COLOUR_W-1:0] DEF_BG_COLOUR = 9'h000;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic {StClear, StRun} wr_state_e;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] y,
                                                input logic [ADDR_W-1:0] x,
                                                input int unsigned width);
    return y * ADDR_W'(width) + x;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v scan counters with active/hsync/vsync decode and first-pixel flag.
// All decoded outputs are combinational from the current counter values.
module vga_timing_gen
  import framebuffer_scanout_pkg::*;
#(
  parameter int unsigned FB_W   = DEF_FB_W,
  parameter int unsigned FB_H   = DEF_FB_H,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             first_o
);

  localparam int unsigned H_TOTAL = FB_W + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = FB_H + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(FB_W);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(FB_H);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(FB_W + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(FB_W + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(FB_H + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(FB_H + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign active_o = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_o  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vsync_o  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign first_o  = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// Plot-write framebuffer with clear-on-reset and raster scanout with VGA sync.
// Optional macro CLIP_COUNT_EN adds a saturating count of out-of-range plots (clip_count).
module framebuffer_scanout
  import framebuffer_scanout_pkg::*;
#(
  parameter int unsigned         FB_W      = DEF_FB_W,
  parameter int unsigned         FB_H      = DEF_FB_H,
  parameter int unsigned         H_FP      = DEF_H_FP,
  parameter int unsigned         H_SYNC    = DEF_H_SYNC,
  parameter int unsigned         H_BP      = DEF_H_BP,
  parameter int unsigned         V_FP      = DEF_V_FP,
  parameter int unsigned         V_SYNC    = DEF_V_SYNC,
  parameter int unsigned         V_BP      = DEF_V_BP,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot_valid,
  input  logic [7:0]          plot_x,
  input  logic [7:0]          plot_y,
  input  logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_ready,
  output logic                clear_busy,
  output logic                hsync_n,
  output logic                vsync_n,
  output logic                blank_n,
  output logic [2:0]          pix_r,
  output logic [2:0]          pix_g,
  output logic [2:0]          pix_b,
  output logic                frame_start
`ifdef CLIP_COUNT_EN
  ,
  output logic [15:0]         clip_count
`endif
);

  localparam int unsigned        FB_DEPTH = FB_W * FB_H;
  localparam int unsigned        MEM_AW   = $clog2(FB_DEPTH);
  localparam logic [ADDR_W-1:0]  CLR_LAST = ADDR_W'(FB_DEPTH - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hsync, vsync, first;

  vga_timing_gen #(
    .FB_W   (FB_W),
    .FB_H   (FB_H),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk      (clk),
    .resetn   (resetn),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .active_o (active),
    .hsync_o  (hsync),
    .vsync_o  (vsync),
    .first_o  (first)
  );

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    plot_ready = 1'b0;
    clear_busy = 1'b0;
    unique case (state_q)
      StClear: begin
        clear_busy = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == CLR_LAST) state_d = StRun;
      end
      StRun: plot_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  logic                plot_accept, plot_in_range;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [COLOUR_W-1:0] wr_data;

  assign plot_accept   = plot_valid && plot_ready;
  assign plot_in_range = (32'(plot_x) < FB_W) && (32'(plot_y) < FB_H);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = BG_COLOUR;
    end else if (plot_accept && plot_in_range) begin
      wr_en   = 1'b1;
      wr_addr = fb_addr(ADDR_W'(plot_y), ADDR_W'(plot_x), FB_W);
      wr_data = plot_colour;
    end
  end

  // Blanking-time reads are parked at 0 so the read index always stays in range.
  assign rd_addr = active ? fb_addr(ADDR_W'(v_cnt), ADDR_W'(h_cnt), FB_W) : '0;

  logic [COLOUR_W-1:0] mem [FB_DEPTH];
  logic [COLOUR_W-1:0] rd_data_q;

  // Nonblocking read and write on the same edge give read-before-write behaviour.
  always_ff @(posedge clk) begin
    if (wr_en && resetn) mem[wr_addr[MEM_AW-1:0]] <= wr_data;
    rd_data_q <= mem[rd_addr[MEM_AW-1:0]];
  end

  logic blank_q, hsync_n_q, vsync_n_q, frame_start_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      blank_q       <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= active;
      hsync_n_q     <= ~hsync;
      vsync_n_q     <= ~vsync;
      frame_start_q <= first;
    end
  end

  assign blank_n     = blank_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign frame_start = frame_start_q;
  assign pix_r       = blank_q ? rd_data_q[R_HI:R_LO] : '0;
  assign pix_g       = blank_q ? rd_data_q[G_HI:G_LO] : '0;
  assign pix_b       = blank_q ? rd_data_q[B_HI:B_LO] : '0;

`ifdef CLIP_COUNT_EN
  logic [15:0] clip_count_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clip_count_q <= '0;
    end else if (plot_accept && !plot_in_range && (clip_count_q != 16'hFFFF)) begin
      clip_count_q <= clip_count_q + 16'd1;
    end
  end

  assign clip_count = clip_count_q;
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on an 8x4 framebuffer (12-cycle lines, 7-line frames).
module tb_framebuffer_scanout;

  localparam int FB_W  = 8;
  localparam int FB_H  = 4;
  localparam int LINE  = 12;
  localparam int FRAME = 84;

  logic       clk = 1'b0;
  logic       resetn;
  logic       plot_valid;
  logic [7:0] plot_x, plot_y;
  logic [8:0] plot_colour;
  logic       plot_ready, clear_busy, hsync_n, vsync_n, blank_n, frame_start;
  logic [2:0] pix_r, pix_g, pix_b;
  logic [8:0] pix_all;
`ifdef CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int         checks = 0;
  int         errors = 0;
  int         k;
  logic [8:0] model [FB_W*FB_H];

  assign pix_all = {pix_r, pix_g, pix_b};

  framebuffer_scanout #(
    .FB_W      (8),
    .FB_H      (4),
    .H_FP      (1),
    .H_SYNC    (2),
    .H_BP      (1),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1),
    .BG_COLOUR (9'h000)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .plot_valid  (plot_valid),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot_ready  (plot_ready),
    .clear_busy  (clear_busy),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .blank_n     (blank_n),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .frame_start (frame_start)
`ifdef CLIP_COUNT_EN
    ,
    .clip_count  (clip_count)
`endif
  );

  always #5 clk = ~clk;

  // k = index of the last rising edge since reset release; outputs then reflect scan index k.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic wait_until(input int n);
    for (int i = 0; i < FRAME && (k % FRAME) != n; i++) step();
  endtask

  function automatic logic exp_blank(input int n);
    int h = n % LINE;
    int v = n / LINE;
    return (h < FB_W) && (v < FB_H);
  endfunction

  function automatic logic [8:0] exp_pix(input int n);
    int h = n % LINE;
    int v = n / LINE;
    return exp_blank(n) ? model[v*FB_W+h] : 9'h000;
  endfunction

  function automatic logic exp_hs_n(input int n);
    int h = n % LINE;
    return !(h >= 9 && h < 11);
  endfunction

  function automatic logic exp_vs_n(input int n);
    return (n / LINE) != 5;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; plot_valid = 1'b0; plot_x = '0; plot_y = '0; plot_colour = '0;
    for (int i = 0; i < FB_W*FB_H; i++) model[i] = 9'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    k = -1;
    checks += 5;
    if (hsync_n !== 1'b1) begin errors++; $display("FAIL reset_hsync_n: got %b expected 1", hsync_n); end
    if (vsync_n !== 1'b1) begin errors++; $display("FAIL reset_vsync_n: got %b expected 1", vsync_n); end
    if (blank_n !== 1'b0) begin errors++; $display("FAIL reset_blank_n: got %b expected 0", blank_n); end
    if (pix_all !== 9'h000) begin errors++; $display("FAIL reset_pix: got %h expected 000", pix_all); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
`ifdef CLIP_COUNT_EN
    checks++;
    if (clip_count !== 16'd0) begin errors++; $display("FAIL reset_clip_count: got %0d expected 0", clip_count); end
`endif
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (clear_busy !== 1'b1 || plot_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_window k=%0d: got busy=%b ready=%b expected busy=1 ready=0", k, clear_busy, plot_ready);
      end
      step();
    end
    checks++;
    if (clear_busy !== 1'b0 || plot_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_done: got busy=%b ready=%b expected busy=0 ready=1", clear_busy, plot_ready);
    end
  endtask

  task automatic test_blank_frame();
    wait_until(FRAME - 1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (blank_n !== exp_blank(k % FRAME) || pix_all !== 9'h000) begin
        errors++;
        $display("FAIL cleared_frame n=%0d: got blank_n=%b pix=%h expected blank_n=%b pix=000",
                 k % FRAME, blank_n, pix_all, exp_blank(k % FRAME));
      end
    end
  endtask

  task automatic test_timing();
    int fs_count = 0;
    int last_fs  = -1;
    wait_until(FRAME - 1);
    for (int i = 0; i < 2*FRAME; i++) begin
      step();
      checks++;
      if (hsync_n !== exp_hs_n(k % FRAME) || vsync_n !== exp_vs_n(k % FRAME) ||
          frame_start !== ((k % FRAME) == 0)) begin
        errors++;
        $display("FAIL sync n=%0d: got hs_n=%b vs_n=%b fs=%b expected hs_n=%b vs_n=%b fs=%b",
                 k % FRAME, hsync_n, vsync_n, frame_start, exp_hs_n(k % FRAME),
                 exp_vs_n(k % FRAME), (k % FRAME) == 0);
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (k - last_fs != FRAME) begin
            errors++; $display("FAIL frame_period: got %0d expected %0d", k - last_fs, FRAME);
          end
        end
        last_fs = k;
        fs_count++;
      end
    end
    checks++;
    if (fs_count != 2) begin errors++; $display("FAIL frame_start_count: got %0d expected 2", fs_count); end
  endtask

  task automatic test_plot();
    wait_until(FRAME - 1);
    checks++;
    if (plot_ready !== 1'b1) begin errors++; $display("FAIL plot_ready_run: got %b expected 1", plot_ready); end
    plot_valid = 1'b1; plot_x = 8'd3; plot_y = 8'd2; plot_colour = 9'b101_010_111;
    step();
    plot_valid = 1'b0;
    model[2*FB_W+3] = 9'b101_010_111;
    wait_until(FRAME - 1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if ((k % FRAME) == 27) begin
        checks++;
        if (pix_r !== 3'd5 || pix_g !== 3'd2 || pix_b !== 3'd7 || blank_n !== 1'b1) begin
          errors++;
          $display("FAIL plot_pixel: got r=%0d g=%0d b=%0d blank_n=%b expected r=5 g=2 b=7 blank_n=1",
                   pix_r, pix_g, pix_b, blank_n);
        end
      end else begin
        checks++;
        if (pix_all !== exp_pix(k % FRAME)) begin
          errors++;
          $display("FAIL plot_frame n=%0d: got %h expected %h", k % FRAME, pix_all, exp_pix(k % FRAME));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    wait_until(FRAME - 1);
    plot_valid = 1'b1; plot_x = 8'd8; plot_y = 8'd0; plot_colour = 9'h1FF;
    checks++;
    if (plot_ready !== 1'b1) begin errors++; $display("FAIL oor_ready_x: got %b expected 1", plot_ready); end
    step();
    plot_x = 8'd0; plot_y = 8'd4; plot_colour = 9'h0AA;
    checks++;
    if (plot_ready !== 1'b1) begin errors++; $display("FAIL oor_ready_y: got %b expected 1", plot_ready); end
    step();
    plot_valid = 1'b0;
    wait_until(FRAME - 1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (pix_all !== exp_pix(k % FRAME)) begin
        errors++;
        $display("FAIL oor_frame n=%0d: got %h expected %h", k % FRAME, pix_all, exp_pix(k % FRAME));
      end
    end
`ifdef CLIP_COUNT_EN
    checks++;
    if (clip_count !== 16'd2) begin errors++; $display("FAIL clip_count: got %0d expected 2", clip_count); end
`endif
  endtask

  task automatic test_same_address();
    wait_until(12);
    plot_valid = 1'b1; plot_x = 8'd1; plot_y = 8'd1; plot_colour = 9'h1C5;
    step();
    plot_valid = 1'b0;
    checks++;
    if (pix_all !== 9'h000 || blank_n !== 1'b1) begin
      errors++;
      $display("FAIL same_addr_old: got pix=%h blank_n=%b expected pix=000 blank_n=1", pix_all, blank_n);
    end
    model[1*FB_W+1] = 9'h1C5;
    wait_until(12);
    step();
    checks++;
    if (pix_all !== 9'h1C5) begin errors++; $display("FAIL same_addr_new: got %h expected 1c5", pix_all); end
  endtask

  task automatic test_reset_mid_clear();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    k = -1;
    repeat (17) step();
    resetn = 1'b0;
    plot_valid = 1'b1; plot_x = 8'd2; plot_y = 8'd0; plot_colour = 9'h1FF;
    step();
    resetn = 1'b1;
    plot_valid = 1'b0;
    k = -1;
    for (int i = 0; i < FB_W*FB_H; i++) model[i] = 9'h000;
`ifdef CLIP_COUNT_EN
    checks++;
    if (clip_count !== 16'd0) begin errors++; $display("FAIL rst_clip_count: got %0d expected 0", clip_count); end
`endif
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (clear_busy !== 1'b1 || hsync_n !== ((k < 0) ? 1'b1 : exp_hs_n(k)) ||
          frame_start !== (k == 0)) begin
        errors++;
        $display("FAIL reclear k=%0d: got busy=%b hs_n=%b fs=%b expected busy=1 hs_n=%b fs=%b",
                 k, clear_busy, hsync_n, frame_start, (k < 0) ? 1'b1 : exp_hs_n(k), k == 0);
      end
      step();
    end
    checks++;
    if (clear_busy !== 1'b0) begin errors++; $display("FAIL reclear_done: got %b expected 0", clear_busy); end
    wait_until(FRAME - 1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (pix_all !== exp_pix(k % FRAME) || blank_n !== exp_blank(k % FRAME)) begin
        errors++;
        $display("FAIL reclear_frame n=%0d: got pix=%h blank_n=%b expected pix=%h blank_n=%b",
                 k % FRAME, pix_all, blank_n, exp_pix(k % FRAME), exp_blank(k % FRAME));
      end
    end
  endtask

  initial begin
    test_reset();
    test_blank_frame();
    test_timing();
    test_plot();
    test_out_of_range();
    test_same_address();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
